pdbl_sequencer: RTL and testbench

- Sequences one projective point doubling on twisted Edwards curve a=-1 over GF(p), p = 2^255-19 (formula dbl-2008-bbjlp).
- Shares one external pipelined modular multiplier through a valid/ready request port and a response port.
- Performs all modular add/sub internally, one operation per cycle.
- Sits between the x25519 scalar-multiply control FSM and the shared field multiplier.

---
 rtl/pdbl_sequencer_if.sv | 22 ++
 rtl/pdbl_sequencer.sv | 226 ++++++++++++++++++++++
 tb/tb_pdbl_sequencer.sv | 374 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pdbl_sequencer_if.sv
// Request/response port to the shared pipelined GF(2^255-19) multiplier.
// The sequencer drives the master side; the multiplier (or a bench model) is the slave.
interface pdbl_sequencer_if #(
    parameter int W = 256
);
    logic         mul_req_valid;
    logic         mul_req_ready;
    logic [W-1:0] mul_a;
    logic [W-1:0] mul_b;
    logic         mul_rsp_valid;
    logic [W-1:0] mul_rsp_data;

    modport master (
        output mul_req_valid, mul_a, mul_b,
        input  mul_req_ready, mul_rsp_valid, mul_rsp_data
    );

    modport slave (
        input  mul_req_valid, mul_a, mul_b,
        output mul_req_ready, mul_rsp_valid, mul_rsp_data
    );
endinterface

// File: rtl/pdbl_sequencer.sv
// Projective point doubling (twisted Edwards a=-1, dbl-2008-bbjlp) over GF(2^255-19)
// sharing one external multiplier. Optional busy-cycle counter: PDBL_CYCLE_COUNT_EN.
module pdbl_sequencer #(
    parameter int           W = 256,
    parameter logic [W-1:0] P = 256'h7fffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffed
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] x1,
    input  logic [W-1:0] y1,
    input  logic [W-1:0] z1,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] x2,
    output logic [W-1:0] y2,
    output logic [W-1:0] z2,
`ifdef PDBL_CYCLE_COUNT_EN
    output logic [15:0]  cycles,
`endif
    pdbl_sequencer_if.master mul
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PRE   = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_ALU   = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    // Operands are always < P, so one conditional correction suffices.
    function automatic logic [W-1:0] add_mod(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, P}) s = s - {1'b0, P};
        return s[W-1:0];
    endfunction

    function automatic logic [W-1:0] sub_mod(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] d;
        d = {1'b0, a} - {1'b0, b};
        if (d[W]) d = d + {1'b0, P};
        return d[W-1:0];
    endfunction

    state_t       state_q, state_d;
    logic [2:0]   op_q, op_d;
    logic [2:0]   alu_q, alu_d;

    logic [W-1:0] x1_q, y1_q, z1_q, t0_q;
    logic [W-1:0] b_q, c_q, d_q, h_q;
    logic [W-1:0] e_q, f_q, j_q, g_q, k_q;
    logic [W-1:0] x3_q, y3_q;
    logic [W-1:0] x2_q, y2_q, z2_q;

    logic         load_in, pre_we, rsp_we, alu_we, out_we;
    logic [W-1:0] op_a, op_b, alu_res;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= 3'd0;
            alu_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            alu_q   <= alu_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        alu_d   = alu_q;
        load_in = 1'b0;
        pre_we  = 1'b0;
        rsp_we  = 1'b0;
        alu_we  = 1'b0;
        out_we  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    load_in = 1'b1;
                    state_d = S_PRE;
                end
            end
            S_PRE: begin
                pre_we  = 1'b1;
                op_d    = 3'd0;
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                if (mul.mul_req_ready) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (mul.mul_rsp_valid) begin
                    rsp_we = 1'b1;
                    if (op_q == 3'd3) begin
                        alu_d   = 3'd0;
                        state_d = S_ALU;
                    end else if (op_q == 3'd6) begin
                        out_we  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        op_d    = op_q + 3'd1;
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ALU: begin
                alu_we = 1'b1;
                if (alu_q == 3'd4) begin
                    op_d    = 3'd4;
                    state_d = S_ISSUE;
                end else begin
                    alu_d = alu_q + 3'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------------------------------------------------- multiplier
    always_comb begin
        op_a = '0;
        op_b = '0;
        case (op_q)
            3'd0:    begin op_a = t0_q; op_b = t0_q; end
            3'd1:    begin op_a = x1_q; op_b = x1_q; end
            3'd2:    begin op_a = y1_q; op_b = y1_q; end
            3'd3:    begin op_a = z1_q; op_b = z1_q; end
            3'd4:    begin op_a = g_q;  op_b = j_q;  end
            3'd5:    begin op_a = f_q;  op_b = k_q;  end
            3'd6:    begin op_a = f_q;  op_b = j_q;  end
            default: begin op_a = '0;   op_b = '0;   end
        endcase
    end

    // Operands are gated to zero outside ISSUE so the bus is quiet when idle.
    assign mul.mul_req_valid = (state_q == S_ISSUE);
    assign mul.mul_a         = (state_q == S_ISSUE) ? op_a : '0;
    assign mul.mul_b         = (state_q == S_ISSUE) ? op_b : '0;

    // ----------------------------------------------------------------- ALU
    always_comb begin
        alu_res = '0;
        case (alu_q)
            3'd0:    alu_res = sub_mod('0, c_q);
            3'd1:    alu_res = add_mod(e_q, d_q);
            3'd2:    alu_res = sub_mod(sub_mod(f_q, h_q), h_q);
            3'd3:    alu_res = sub_mod(sub_mod(b_q, c_q), d_q);
            3'd4:    alu_res = sub_mod(e_q, d_q);
            default: alu_res = '0;
        endcase
    end

    // Working registers need no reset: every one is written before it is read.
    always_ff @(posedge clk) begin
        if (load_in) begin
            x1_q <= x1;
            y1_q <= y1;
            z1_q <= z1;
        end
        if (pre_we) t0_q <= add_mod(x1_q, y1_q);
        if (rsp_we) begin
            case (op_q)
                3'd0:    b_q  <= mul.mul_rsp_data;
                3'd1:    c_q  <= mul.mul_rsp_data;
                3'd2:    d_q  <= mul.mul_rsp_data;
                3'd3:    h_q  <= mul.mul_rsp_data;
                3'd4:    x3_q <= mul.mul_rsp_data;
                3'd5:    y3_q <= mul.mul_rsp_data;
                default: ;
            endcase
        end
        if (alu_we) begin
            case (alu_q)
                3'd0:    e_q <= alu_res;
                3'd1:    f_q <= alu_res;
                3'd2:    j_q <= alu_res;
                3'd3:    g_q <= alu_res;
                default: k_q <= alu_res;
            endcase
        end
    end

    // Z3 lands straight from the last product so results are visible in the DONE cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            x2_q <= '0;
            y2_q <= '0;
            z2_q <= '0;
        end else if (out_we) begin
            x2_q <= x3_q;
            y2_q <= y3_q;
            z2_q <= mul.mul_rsp_data;
        end
    end

    assign x2   = x2_q;
    assign y2   = y2_q;
    assign z2   = z2_q;
    assign busy = (state_q != S_IDLE);
    assign done = (state_q == S_DONE);

`ifdef PDBL_CYCLE_COUNT_EN
    logic [15:0] cycles_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cycles_q <= 16'd0;
        end else if (state_q == S_IDLE) begin
            if (start) cycles_q <= 16'd0;
        end else if (cycles_q != 16'hffff) begin
            cycles_q <= cycles_q + 16'd1;
        end
    end

    assign cycles = cycles_q;
`endif

endmodule

// File: tb/tb_pdbl_sequencer.sv
// Directed and random bench for pdbl_sequencer with a behavioural multiplier that
// supports ready stalls, response latency and spurious response pulses.
module tb_pdbl_sequencer;

    localparam int           W   = 256;
    localparam logic [255:0] P   = 256'h7fffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffed;
    localparam logic [255:0] PM1 = P - 256'd1;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [255:0] x1, y1, z1;
    logic         busy, done;
    logic [255:0] x2, y2, z2;
`ifdef PDBL_CYCLE_COUNT_EN
    logic [15:0]  cycles;
`endif

    pdbl_sequencer_if #(.W(W)) mif ();

    pdbl_sequencer dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .x1    (x1),
        .y1    (y1),
        .z1    (z1),
        .busy  (busy),
        .done  (done),
        .x2    (x2),
        .y2    (y2),
        .z2    (z2),
`ifdef PDBL_CYCLE_COUNT_EN
        .cycles(cycles),
`endif
        .mul   (mif.master)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // multiplier model configuration (written by the main sequence only)
    int rdy_stall = 0;
    int rsp_lat   = 1;
    bit spur      = 0;

    // counters owned by the responder / monitor
    int hs_cnt     = 0;
    int stab_err   = 0;
    int stall_seen = 0;
    int cyc        = 0;
    int busy_total = 0;
    int done_total = 0;

    function automatic logic [255:0] addm(input logic [255:0] a, input logic [255:0] b);
        logic [256:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, P}) s = s - {1'b0, P};
        return s[255:0];
    endfunction

    function automatic logic [255:0] subm(input logic [255:0] a, input logic [255:0] b);
        logic [256:0] d;
        d = {1'b0, a} + {1'b0, P} - {1'b0, b};
        if (d >= {1'b0, P}) d = d - {1'b0, P};
        return d[255:0];
    endfunction

    function automatic logic [255:0] mulm(input logic [255:0] a, input logic [255:0] b);
        logic [255:0] r;
        r = '0;
        for (int i = 255; i >= 0; i--) begin
            r = addm(r, r);
            if (b[i]) r = addm(r, a);
        end
        return r;
    endfunction

    task automatic ref_dbl(input logic [255:0] x, input logic [255:0] y, input logic [255:0] z,
                           output logic [255:0] ex, output logic [255:0] ey, output logic [255:0] ez);
        logic [255:0] b, c, d, e, f, h, j;
        b  = mulm(addm(x, y), addm(x, y));
        c  = mulm(x, x);
        d  = mulm(y, y);
        h  = mulm(z, z);
        e  = subm(256'd0, c);
        f  = addm(e, d);
        j  = subm(f, addm(h, h));
        ex = mulm(subm(b, addm(c, d)), j);
        ey = mulm(f, subm(e, d));
        ez = mulm(f, j);
    endtask

    function automatic logic [255:0] rnd_fe();
        logic [255:0] v;
        v = {$urandom(), $urandom(), $urandom(), $urandom(),
             $urandom(), $urandom(), $urandom(), $urandom()};
        v[255] = 1'b0;
        if (v >= P) v = v - P;
        return v;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (busy === 1'b1) busy_total <= busy_total + 1;
        if (done === 1'b1) done_total <= done_total + 1;
    end

    // Behavioural multiplier: rdy_stall ready-low cycles per request, response
    // rsp_lat cycles after the handshake edge (1 = the very next cycle).
    initial begin
        logic [255:0] la, lb, pa, pb, pdata;
        bit armed, hp;
        int pend, sn;
        armed = 0; hp = 0; pend = 0; sn = 0;
        la = '0; lb = '0; pa = '0; pb = '0; pdata = '0;
        mif.mul_req_ready = 1'b0;
        mif.mul_rsp_valid = 1'b0;
        mif.mul_rsp_data  = '0;
        forever begin
            @(negedge clk);
            mif.mul_rsp_valid = 1'b0;
            if (armed) begin
                armed = 0;
                mif.mul_req_ready = 1'b0;
                hs_cnt++;
                pend  = rsp_lat;
                pdata = mulm(la, lb);
                sn = 0;
                hp = 0;
            end
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    mif.mul_rsp_valid = 1'b1;
                    mif.mul_rsp_data  = pdata;
                end
            end else if (mif.mul_req_valid === 1'b1) begin
                if (hp && (mif.mul_a !== pa || mif.mul_b !== pb)) stab_err++;
                pa = mif.mul_a;
                pb = mif.mul_b;
                hp = 1;
                if (sn < rdy_stall) begin
                    sn++;
                    stall_seen++;
                    if (spur) begin
                        mif.mul_rsp_valid = 1'b1;
                        mif.mul_rsp_data  = {$urandom(), $urandom(), $urandom(), $urandom(),
                                             $urandom(), $urandom(), $urandom(), $urandom()};
                    end
                end else begin
                    mif.mul_req_ready = 1'b1;
                    armed = 1;
                    la = pa;
                    lb = pb;
                end
            end
        end
    end

    // Starts one doubling and returns at the negedge where done is seen.
    task automatic run_dbl(input logic [255:0] xi, input logic [255:0] yi, input logic [255:0] zi,
                           output int lat, output bit tmo);
        int sc;
        @(negedge clk);
        x1 = xi; y1 = yi; z1 = zi; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        sc  = cyc;
        tmo = 1;
        for (int i = 0; i < 500; i++) begin
            if (done === 1'b1) begin
                tmo = 0;
                break;
            end
            @(negedge clk);
        end
        lat = cyc - sc;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; x1 = '0; y1 = '0; z1 = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if ((x2 | y2 | z2) !== 256'd0) begin failures++; $display("FAIL reset_xyz got=%h %h %h exp=0", x2, y2, z2); end
        checks++; if (mif.mul_req_valid !== 1'b0) begin failures++; $display("FAIL reset_reqv got=%b exp=0", mif.mul_req_valid); end
        checks++; if ((mif.mul_a | mif.mul_b) !== 256'd0) begin failures++; $display("FAIL reset_ab got=%h %h exp=0", mif.mul_a, mif.mul_b); end
`ifdef PDBL_CYCLE_COUNT_EN
        checks++; if (cycles !== 16'd0) begin failures++; $display("FAIL reset_cycles got=%0d exp=0", cycles); end
`endif
    endtask

    task automatic test_identity;
        int lat, b0, d0;
        bit tmo;
        rdy_stall = 0; rsp_lat = 1; spur = 0;
        b0 = busy_total; d0 = done_total;
        run_dbl(256'd0, 256'd1, 256'd1, lat, tmo);
        checks++; if (tmo) begin failures++; $display("FAIL ident_timeout got=no_done exp=done"); end
        checks++; if (x2 !== 256'd0) begin failures++; $display("FAIL ident_x2 got=%h exp=0", x2); end
        checks++; if (y2 !== PM1) begin failures++; $display("FAIL ident_y2 got=%h exp=%h", y2, PM1); end
        checks++; if (z2 !== PM1) begin failures++; $display("FAIL ident_z2 got=%h exp=%h", z2, PM1); end
        checks++; if (lat !== 20) begin failures++; $display("FAIL ident_latency got=%0d exp=20", lat); end
        @(negedge clk);
        checks++; if (busy_total - b0 !== 21) begin failures++; $display("FAIL ident_busy_cycles got=%0d exp=21", busy_total - b0); end
        checks++; if (done_total - d0 !== 1) begin failures++; $display("FAIL ident_done_count got=%0d exp=1", done_total - d0); end
`ifdef PDBL_CYCLE_COUNT_EN
        checks++; if (cycles !== 16'd21) begin failures++; $display("FAIL ident_cycles got=%0d exp=21", cycles); end
        repeat (3) @(negedge clk);
        checks++; if (cycles !== 16'd21) begin failures++; $display("FAIL ident_cycles_frozen got=%0d exp=21", cycles); end
`endif
    endtask

    task automatic test_wrap;
        int lat;
        bit tmo;
        rdy_stall = 0; rsp_lat = 1; spur = 0;
        run_dbl(256'd1, 256'd0, 256'd1, lat, tmo);
        checks++; if (tmo) begin failures++; $display("FAIL wrap_timeout got=no_done exp=done"); end
        checks++; if (x2 !== 256'd0) begin failures++; $display("FAIL wrap_x2 got=%h exp=0", x2); end
        checks++; if (y2 !== 256'd1) begin failures++; $display("FAIL wrap_y2 got=%h exp=1", y2); end
        checks++; if (z2 !== 256'd3) begin failures++; $display("FAIL wrap_z2 got=%h exp=3", z2); end
        @(negedge clk);
    endtask

    task automatic test_backpressure;
        int lat, s0, e0, b0;
        bit tmo;
        rdy_stall = 3; rsp_lat = 3; spur = 0;
        s0 = stall_seen; e0 = stab_err; b0 = busy_total;
        run_dbl(256'd0, 256'd1, 256'd1, lat, tmo);
        checks++; if (tmo) begin failures++; $display("FAIL bp_timeout got=no_done exp=done"); end
        checks++; if (lat !== 55) begin failures++; $display("FAIL bp_latency got=%0d exp=55", lat); end
        checks++; if (x2 !== 256'd0) begin failures++; $display("FAIL bp_x2 got=%h exp=0", x2); end
        checks++; if (y2 !== PM1) begin failures++; $display("FAIL bp_y2 got=%h exp=%h", y2, PM1); end
        checks++; if (z2 !== PM1) begin failures++; $display("FAIL bp_z2 got=%h exp=%h", z2, PM1); end
        @(negedge clk);
        checks++; if (stall_seen - s0 !== 21) begin failures++; $display("FAIL bp_stalls got=%0d exp=21", stall_seen - s0); end
        checks++; if (stab_err - e0 !== 0) begin failures++; $display("FAIL bp_operand_stable got=%0d exp=0", stab_err - e0); end
        checks++; if (busy_total - b0 !== 56) begin failures++; $display("FAIL bp_busy_cycles got=%0d exp=56", busy_total - b0); end
`ifdef PDBL_CYCLE_COUNT_EN
        checks++; if (cycles !== 16'd56) begin failures++; $display("FAIL bp_cycles got=%0d exp=56", cycles); end
`endif
    endtask

    task automatic test_spurious;
        int lat, d0;
        bit tmo;
        rdy_stall = 2; rsp_lat = 1; spur = 1;
        d0 = done_total;
        fork
            run_dbl(256'd1, 256'd0, 256'd1, lat, tmo);
            begin
                repeat (4) @(negedge clk);
                start = 1'b1; x1 = 256'd7; y1 = 256'd9; z1 = 256'd5;
                @(negedge clk);
                start = 1'b0;
                repeat (9) @(negedge clk);
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                repeat (10) @(negedge clk);
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
        join
        spur = 0;
        checks++; if (tmo) begin failures++; $display("FAIL spur_timeout got=no_done exp=done"); end
        checks++; if (lat !== 34) begin failures++; $display("FAIL spur_latency got=%0d exp=34", lat); end
        checks++; if (x2 !== 256'd0) begin failures++; $display("FAIL spur_x2 got=%h exp=0", x2); end
        checks++; if (y2 !== 256'd1) begin failures++; $display("FAIL spur_y2 got=%h exp=1", y2); end
        checks++; if (z2 !== 256'd3) begin failures++; $display("FAIL spur_z2 got=%h exp=3", z2); end
        repeat (40) @(negedge clk);
        checks++; if (done_total - d0 !== 1) begin failures++; $display("FAIL spur_done_count got=%0d exp=1", done_total - d0); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL spur_idle got=%b exp=0", busy); end
    endtask

    task automatic test_reset_mid;
        int lat, d0, h0;
        bit tmo, seen;
        rdy_stall = 0; rsp_lat = 6; spur = 0;
        d0 = done_total; h0 = hs_cnt; seen = 0;
        @(negedge clk);
        x1 = 256'd0; y1 = 256'd1; z1 = 256'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (hs_cnt >= h0 + 3) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        checks++; if (!seen) begin failures++; $display("FAIL rmid_op2_timeout got=%0d exp=%0d", hs_cnt - h0, 3); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rmid_busy got=%b exp=0", busy); end
        checks++; if (done_total - d0 !== 0) begin failures++; $display("FAIL rmid_done_count got=%0d exp=0", done_total - d0); end
        checks++; if ((x2 | y2 | z2) !== 256'd0) begin failures++; $display("FAIL rmid_xyz got=%h %h %h exp=0", x2, y2, z2); end
        checks++; if (mif.mul_req_valid !== 1'b0) begin failures++; $display("FAIL rmid_reqv got=%b exp=0", mif.mul_req_valid); end
        rsp_lat = 1;
        run_dbl(256'd1, 256'd0, 256'd1, lat, tmo);
        checks++; if (tmo || lat !== 20) begin failures++; $display("FAIL rmid_restart_latency got=%0d exp=20", lat); end
        checks++; if ({x2, y2, z2} !== {256'd0, 256'd1, 256'd3}) begin failures++; $display("FAIL rmid_restart_result got=%h %h %h exp=0 1 3", x2, y2, z2); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int lat1, lat2;
        bit tmo1, tmo2;
        rdy_stall = 0; rsp_lat = 1; spur = 0;
        run_dbl(256'd0, 256'd1, 256'd1, lat1, tmo1);
        checks++; if (tmo1 || {x2, y2, z2} !== {256'd0, PM1, PM1}) begin failures++; $display("FAIL b2b_first got=%h %h %h exp=0 p-1 p-1", x2, y2, z2); end
        run_dbl(256'd1, 256'd0, 256'd1, lat2, tmo2);
        checks++; if (tmo2 || lat2 !== 20) begin failures++; $display("FAIL b2b_latency got=%0d exp=20", lat2); end
        checks++; if ({x2, y2, z2} !== {256'd0, 256'd1, 256'd3}) begin failures++; $display("FAIL b2b_second got=%h %h %h exp=0 1 3", x2, y2, z2); end
        @(negedge clk);
    endtask

    task automatic test_random;
        logic [255:0] vx, vy, vz, ex, ey, ez;
        int lat;
        bit tmo;
        rdy_stall = 0; rsp_lat = 1; spur = 0;
        for (int n = 0; n < 1000; n++) begin
            case (n)
                0:       begin vx = PM1;      vy = PM1;      vz = PM1;      end
                1:       begin vx = 256'd2;   vy = PM1;      vz = 256'd0;   end
                2:       begin vx = rnd_fe(); vy = rnd_fe(); vz = 256'd1;   end
                default: begin vx = rnd_fe(); vy = rnd_fe(); vz = rnd_fe(); end
            endcase
            ref_dbl(vx, vy, vz, ex, ey, ez);
            run_dbl(vx, vy, vz, lat, tmo);
            checks++;
            if (tmo) begin
                failures++;
                $display("FAIL rand_timeout n=%0d got=no_done exp=done", n);
                return;
            end
            checks++; if (x2 !== ex) begin failures++; $display("FAIL rand_x2 n=%0d got=%h exp=%h", n, x2, ex); end
            checks++; if (y2 !== ey) begin failures++; $display("FAIL rand_y2 n=%0d got=%h exp=%h", n, y2, ey); end
            checks++; if (z2 !== ez) begin failures++; $display("FAIL rand_z2 n=%0d got=%h exp=%h", n, z2, ez); end
            @(negedge clk);
`ifdef PDBL_CYCLE_COUNT_EN
            checks++; if (cycles !== 16'd21) begin failures++; $display("FAIL rand_cycles n=%0d got=%0d exp=21", n, cycles); end
`endif
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0;
        x1 = '0; y1 = '0; z1 = '0;
        test_reset;
        test_identity;
        test_wrap;
        test_backpressure;
        test_spurious;
        test_reset_mid;
        test_back_to_back;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
